// File: rtl/posit_decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | posit_decode_stage_pkg: decode-type enum and field-width helpers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package posit_decode_stage_pkg;

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    EXTENDED = 1'b1
  } pd_type_e;

  // NORMAL drops the two bits a minimal regime always consumes; EXTENDED keeps them.
  function automatic int get_fraction_width(input int n, input int es, input pd_type_e t);
    return (t == EXTENDED) ? (n - 1 - es) : (n - 3 - es);
  endfunction

  function automatic int get_scale_width(input int n, input int es, input pd_type_e t);
    return $clog2(n << es) + ((t == EXTENDED) ? 3 : 2);
  endfunction

  function automatic int get_regime_cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pd_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pd_control_if: decoded posit stream with rts/rtr/sow/eow handshake   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pd_control_if import posit_decode_stage_pkg::*; #(
  parameter int       POSIT_WIDTH = 16,
  parameter int       POSIT_ES    = 1,
  parameter pd_type_e PD_TYPE     = NORMAL
) ();

  localparam int c_scale_w = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int c_frac_w  = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

  logic                        rts;
  logic                        rtr;
  logic                        sow;
  logic                        eow;
  logic                        sign;
  logic                        zero;
  logic                        nar;
  logic signed [c_scale_w-1:0] scale;
  logic        [c_frac_w-1:0]  fraction;
  logic                        guard;
  logic                        round;
  logic                        sticky;

  modport master (
    output rts, sow, eow, sign, zero, nar, scale, fraction, guard, round, sticky,
    input  rtr
  );

  modport slave (
    input  rts, sow, eow, sign, zero, nar, scale, fraction, guard, round, sticky,
    output rtr
  );

endinterface
`default_nettype wire

// File: rtl/posit_regime_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | posit_regime_lzc: length of the leading run of bits equal to the MSB |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module posit_regime_lzc #(
  parameter int WIDTH     = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     i_bits,
  output logic [CNT_WIDTH-1:0] o_run_len
);

  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_open;

  always_comb begin
    w_cnt  = '0;
    w_open = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_open && (i_bits[i] == i_bits[WIDTH-1])) begin
        w_cnt = w_cnt + CNT_WIDTH'(1);
      end else begin
        w_open = 1'b0;
      end
    end
  end

  assign o_run_len = w_cnt;

endmodule
`default_nettype wire

// File: rtl/posit_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | posit_decode_stage: two-stage streaming posit field decoder          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module posit_decode_stage import posit_decode_stage_pkg::*; #(
  parameter int       POSIT_WIDTH = 16,
  parameter int       POSIT_ES    = 1,
  parameter pd_type_e PD_TYPE     = NORMAL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_rts,
  output logic                   in_rtr,
  input  logic                   in_sow,
  input  logic                   in_eow,
  input  logic [POSIT_WIDTH-1:0] in_posit,
  pd_control_if.master           out
);

  localparam int c_body_w  = POSIT_WIDTH - 1;
  localparam int c_cnt_w   = get_regime_cnt_width(POSIT_WIDTH);
  localparam int c_sh_w    = c_cnt_w + 1;
  localparam int c_scale_w = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int c_frac_w  = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int c_left    = c_body_w - POSIT_ES - c_frac_w;

  logic                        r_s1_valid, r_s1_sign, r_s1_zero, r_s1_nar, r_s1_sow, r_s1_eow;
  logic [c_body_w-1:0]         r_s1_body;
  logic                        r_s2_valid, r_s2_sign, r_s2_zero, r_s2_nar, r_s2_sow, r_s2_eow;
  logic                        r_s2_sticky;
  logic signed [c_scale_w-1:0] r_s2_scale;
  logic [c_frac_w-1:0]         r_s2_frac;

  logic w_s2_ready, w_s1_ready, w_in_take, w_s2_take;

  assign w_s2_ready = !r_s2_valid || out.rtr;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_rtr     = w_s1_ready;
  assign w_in_take  = in_rts && w_s1_ready;
  assign w_s2_take  = r_s1_valid && w_s2_ready;

  // Low bits of the two's complement only depend on the low input bits.
  logic [c_body_w-1:0] w_body;
  assign w_body = in_posit[POSIT_WIDTH-1] ? (~in_posit[c_body_w-1:0] + c_body_w'(1))
                                          : in_posit[c_body_w-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_sow   <= 1'b0;
      r_s1_eow   <= 1'b0;
      r_s1_body  <= '0;
    end else begin
      if (w_s1_ready) r_s1_valid <= in_rts;
      if (w_in_take) begin
        r_s1_sign <= in_posit[POSIT_WIDTH-1];
        r_s1_zero <= (in_posit == '0);
        r_s1_nar  <= (in_posit == {1'b1, {c_body_w{1'b0}}});
        r_s1_sow  <= in_sow;
        r_s1_eow  <= in_eow;
        r_s1_body <= w_body;
      end
    end
  end

  logic [c_cnt_w-1:0]          w_run;
  logic [c_sh_w-1:0]           w_shamt;
  logic [c_body_w-1:0]         w_tail;
  logic signed [c_scale_w-1:0] w_run_s, w_k, w_scale;
  logic [c_frac_w-1:0]         w_frac;
  logic                        w_sticky;

  posit_regime_lzc #(
    .WIDTH     (c_body_w),
    .CNT_WIDTH (c_cnt_w)
  ) u_lzc (
    .i_bits    (r_s1_body),
    .o_run_len (w_run)
  );

  // Drop the regime run plus its terminating bit; exponent then fraction follow.
  assign w_shamt = {1'b0, w_run} + c_sh_w'(1);
  assign w_tail  = r_s1_body << w_shamt;
  assign w_run_s = signed'({{(c_scale_w - c_cnt_w){1'b0}}, w_run});
  assign w_k     = r_s1_body[c_body_w-1] ? (w_run_s - c_scale_w'(1)) : -w_run_s;

  generate
    if (POSIT_ES > 0) begin : g_exp
      assign w_scale = (w_k <<< POSIT_ES) | c_scale_w'(w_tail[c_body_w-1 -: POSIT_ES]);
    end else begin : g_no_exp
      assign w_scale = w_k;
    end

    if (c_left > 0) begin : g_trim
      assign w_frac   = w_tail[c_body_w-1-POSIT_ES -: c_frac_w];
      assign w_sticky = |w_tail[c_left-1:0];
    end else begin : g_full
      assign w_frac   = w_tail[c_frac_w-1:0];
      assign w_sticky = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_sow    <= 1'b0;
      r_s2_eow    <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_scale  <= '0;
      r_s2_frac   <= '0;
    end else begin
      if (w_s2_ready) r_s2_valid <= r_s1_valid;
      if (w_s2_take) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_zero   <= r_s1_zero;
        r_s2_nar    <= r_s1_nar;
        r_s2_sow    <= r_s1_sow;
        r_s2_eow    <= r_s1_eow;
        r_s2_sticky <= (r_s1_zero || r_s1_nar) ? 1'b0 : w_sticky;
        r_s2_scale  <= (r_s1_zero || r_s1_nar) ? '0 : w_scale;
        r_s2_frac   <= (r_s1_zero || r_s1_nar) ? '0 : w_frac;
      end
    end
  end

  assign out.rts      = r_s2_valid;
  assign out.sow      = r_s2_sow;
  assign out.eow      = r_s2_eow;
  assign out.sign     = r_s2_sign;
  assign out.zero     = r_s2_zero;
  assign out.nar      = r_s2_nar;
  assign out.scale    = r_s2_scale;
  assign out.fraction = r_s2_frac;
  assign out.guard    = 1'b0;
  assign out.round    = 1'b0;
  assign out.sticky   = r_s2_sticky;

endmodule
`default_nettype wire

// File: tb/tb_posit_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_posit_decode_stage: directed + random bench with scoreboard model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_posit_decode_stage;
  import posit_decode_stage_pkg::*;

  localparam int ES = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_rts = 1'b0;
  logic        in_rtr;
  logic        in_sow = 1'b0;
  logic        in_eow = 1'b0;
  logic [15:0] in_posit = 16'h0;
  logic        tb_rtr = 1'b1;
  logic        hold_rtr = 1'b1;
  logic        rand_rtr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [26:0] prev_obs = '0;

  pd_control_if #(.POSIT_WIDTH(16), .POSIT_ES(ES), .PD_TYPE(NORMAL)) u_if ();

  posit_decode_stage #(
    .POSIT_WIDTH (16),
    .POSIT_ES    (ES),
    .PD_TYPE     (NORMAL)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_rts   (in_rts),
    .in_rtr   (in_rtr),
    .in_sow   (in_sow),
    .in_eow   (in_eow),
    .in_posit (in_posit),
    .out      (u_if)
  );

  assign u_if.rtr = tb_rtr;

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    tb_rtr = rand_rtr ? 1'($urandom_range(0, 1)) : hold_rtr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [15:0] v, input int p);
    return (p >= 0) && (((v >> p) & 16'd1) != 16'd0);
  endfunction

  // Reference: walk the magnitude bit by bit as the posit format is defined.
  function automatic logic [26:0] model(input logic [15:0] w, input logic s, input logic e);
    logic sg, z, nr, r;
    logic [15:0] a;
    logic [11:0] fr;
    int i, m, k, ex, sc;
    sg = w[15];
    z  = (w == 16'h0000);
    nr = (w == 16'h8000);
    a  = sg ? 16'(-w) : w;
    sc = 0;
    fr = '0;
    if (!z && !nr) begin
      r = bit_at(a, 14);
      m = 0;
      i = 14;
      while (i >= 0 && bit_at(a, i) == r) begin m++; i--; end
      i--;
      k = r ? m - 1 : -m;
      ex = 0;
      for (int j = 0; j < ES; j++) begin ex = ex * 2 + int'(bit_at(a, i)); i--; end
      for (int j = 0; j < 12; j++) begin fr = {fr[10:0], bit_at(a, i)}; i--; end
      sc = k * (1 << ES) + ex;
    end
    return {s, e, sg, z, nr, 3'b000, 7'(sc), fr};
  endfunction

  function automatic logic [26:0] obs();
    return {u_if.sow, u_if.eow, u_if.sign, u_if.zero, u_if.nar, u_if.guard, u_if.round,
            u_if.sticky, u_if.scale, u_if.fraction};
  endfunction

  // Scoreboard and hold-while-stalled monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold", {5'd0, u_if.rts, obs()}, {5'd0, 1'b1, prev_obs});
      if (u_if.rts && u_if.rtr) begin
        if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
        else check("data", {5'd0, obs()}, {5'd0, exp_q.pop_front()});
      end
      if (in_rts && in_rtr) exp_q.push_back(model(in_posit, in_sow, in_eow));
      stalled  = u_if.rts && !u_if.rtr;
      prev_obs = obs();
    end
  end

  task automatic drive(input logic [15:0] w, input logic s, input logic e);
    in_posit = w;
    in_sow   = s;
    in_eow   = e;
    in_rts   = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_rts   = 1'b0;
    in_posit = 16'($urandom);
    in_sow   = 1'($urandom_range(0, 1));
    in_eow   = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] w, input logic s, input logic e);
    int n;
    @(posedge clk);
    #1;
    drive(w, s, e);
    n = 0;
    @(negedge clk);
    while (!in_rtr && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("send_timeout", 32'(in_rtr), 32'd1);
  endtask

  task automatic send_check(input string tag, input logic [15:0] w, input logic sg,
                            input logic z, input logic nr, input int sc, input logic [11:0] fr);
    send(w, 1'b0, 1'b0);
    idle();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (u_if.rts) break;
    end
    check({tag, "_rts"}, 32'(u_if.rts), 32'd1);
    check(tag, {9'd0, u_if.sign, u_if.zero, u_if.nar, u_if.scale, u_if.fraction},
          {9'd0, sg, z, nr, 7'(sc), fr});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rts", 32'(u_if.rts), 32'd0);
    check("rst_data", {5'd0, obs()}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_rtr", 32'(in_rtr), 32'd1);

    // Back-to-back triple, latency and throughput
    @(posedge clk); #1; drive(16'h4000, 1'b0, 1'b0);
    @(negedge clk); check("t_c0_rtr", 32'(in_rtr), 32'd1);
    @(posedge clk); #1; drive(16'h5000, 1'b0, 1'b0);
    @(negedge clk); check("t_c1_rts", 32'(u_if.rts), 32'd0);
    @(posedge clk); #1; drive(16'h4800, 1'b0, 1'b0);
    @(negedge clk); check("t_c2_rts", 32'(u_if.rts), 32'd1);
    check("t_4000", {12'd0, u_if.sign, u_if.scale, u_if.fraction}, {12'd0, 1'b0, 7'd0, 12'h000});
    idle();
    @(negedge clk); check("t_c3_rts", 32'(u_if.rts), 32'd1);
    check("t_5000", {12'd0, u_if.sign, u_if.scale, u_if.fraction}, {12'd0, 1'b0, 7'd1, 12'h000});
    @(negedge clk); check("t_c4_rts", 32'(u_if.rts), 32'd1);
    check("t_4800", {12'd0, u_if.sign, u_if.scale, u_if.fraction}, {12'd0, 1'b0, 7'd0, 12'h800});
    @(negedge clk); check("t_c5_rts", 32'(u_if.rts), 32'd0);

    // Special values and extremes
    send_check("zero", 16'h0000, 1'b0, 1'b1, 1'b0, 0, 12'h000);
    send_check("nar",  16'h8000, 1'b1, 1'b0, 1'b1, 0, 12'h000);
    send_check("neg1", 16'hC000, 1'b1, 1'b0, 1'b0, 0, 12'h000);
    send_check("minp", 16'h0001, 1'b0, 1'b0, 1'b0, -28, 12'h000);
    send_check("maxp", 16'h7FFF, 1'b0, 1'b0, 1'b0, 28, 12'h000);

    // Back-pressure: fill both stages, stall, then drain in order
    @(posedge clk); #1; hold_rtr = 1'b0;
    idle();
    send(16'h4000, 1'b1, 1'b0);
    send(16'h5800, 1'b0, 1'b0);
    @(posedge clk); #1; drive(16'h2345, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_rtr", 32'(in_rtr), 32'd0);
      check("bp_out_rts", 32'(u_if.rts), 32'd1);
    end
    @(posedge clk); #1; in_rts = 1'b0; hold_rtr = 1'b1;
    send(16'h2345, 1'b0, 1'b0);
    send(16'hB7A1, 1'b0, 1'b0);
    send(16'h0F0F, 1'b0, 1'b1);
    idle();
    repeat (5) @(negedge clk);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random back-pressure
    rand_rtr = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    @(posedge clk); #1; rand_rtr = 1'b0; hold_rtr = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset while both stages hold words
    @(posedge clk); #1; hold_rtr = 1'b0;
    idle();
    send(16'h6000, 1'b1, 1'b0);
    send(16'h1234, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("mr_full_rtr", 32'(in_rtr), 32'd0);
    check("mr_full_rts", 32'(u_if.rts), 32'd1);
    #2; rst_n = 1'b0;
    #1; check("mr_rts_drop", 32'(u_if.rts), 32'd0);
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1; hold_rtr = 1'b1;
    send_check("mr_first", 16'h3400, 1'b0, 1'b0, 1'b0, -1, 12'h400);
    repeat (3) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posit_decode_stage.md
Name: posit_decode_stage

Overview:
- Streaming posit decoder that sits directly upstream of every consumer of pd_control_if.
- Accepts raw posit words over an rts/rtr/sow/eow handshake.
- Drives the decoded fields (sign, scale, fraction, zero, NaR, guard/round/sticky) as a pd_control_if master.
- Two-stage pipeline with full back-pressure; feeds posit arithmetic units.

Parameters:
- POSIT_WIDTH, 16, posit word width N (>= 5).
- POSIT_ES, 1, exponent field width.
- PD_TYPE, NORMAL, pd_type selecting scale/fraction widths via the package functions.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_rts  in  1  upstream has valid word.
- in_rtr  out  1  this block can accept a word.
- in_sow  in  1  start of window, travels with data.
- in_eow  in  1  end of window, travels with data.
- in_posit  in  POSIT_WIDTH  raw posit word.
- out  pd_control_if.master  (POSIT_WIDTH, POSIT_ES, PD_TYPE)  decoded stream; rts/rtr/sow/eow are the output handshake.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0; out.rts = 0; out.sow = out.eow = 0; all out data fields = 0; in_rtr = 1 on first cycle after release.
- Transfer rule: a word moves when rts && rtr in the same rising edge, on both ports.
- Producer rule: out.rts, once high, holds with stable data until out.rtr is seen high.
- Stage 1 (S1) latches on input transfer:
  - sign = msb.
  - zero = (word == 0).
  - NaR = (word == 1 followed by N-1 zeros).
  - abs = two's complement of word when sign = 1, else word.
  - sow/eow.
- Stage 2 (S2), from S1:
  - Regime run: first bit r after the sign; run length m counts identical bits until the first opposite bit or the end of the word.
  - k = m-1 when r = 1, else -m.
  - Exponent: next ES bits, missing bits padded with 0.
  - scale = k*2^ES + e, signed, width scale_width.
  - fraction = remaining bits left-aligned into fraction_width, zero-padded on the right, no hidden bit.
  - guard = round = sticky = 0.
- Zero or NaR: scale = 0 and fraction = 0; sign = msb (NaR sign = 1, zero sign = 0).
- Latency: 2 cycles from input transfer to out.rts when unstalled. Throughput: 1 word/cycle.
- Ready chain:
  - s2_ready = !s2_valid || out.rtr.
  - s1_ready = !s1_valid || s2_ready.
  - in_rtr = s1_ready.
  - Combinational rtr path only; no combinational rts path.
- Simultaneous events:
  - S2 unloading while S1 loading: both occur the same edge, no bubble.
  - Full pipe with out.rtr = 0: in_rtr = 0 and no word is lost or duplicated.
- sow/eow: propagate unchanged with their word. A single word may carry both.
- Reset mid-stream: in-flight words are discarded, and out.rts drops asynchronously.
- in_* data are ignored when in_rts = 0.

Decomposition:
- Shared package (existing posit package): pd_type enum, get_scale_width, get_fraction_width.
- New package function: clog2-based regime-count width.
- Sub-module posit_regime_lzc: combinational leading-run counter returning m, parameterised by width. Instantiated once in S2.
- Pipeline registers and handshake stay in posit_decode_stage.

Test Plan (N=16, ES=1, fraction_width=12, scale_width=7):
- 0x4000, 0x5000, 0x4800 back-to-back with out.rtr = 1:
  - 0x4000 -> {sign 0, scale 0, frac 0x000}
  - 0x5000 -> {scale 1, frac 0x000}
  - 0x4800 -> {scale 0, frac 0x800}
  - out.rts on cycles 2, 3, 4 after the first transfer.
- 0x0000 -> zero = 1, NaR = 0, scale 0.
- 0x8000 -> NaR = 1, sign 1, zero = 0.
- 0xC000 -> sign 1, scale 0, frac 0.
- Extremes:
  - 0x0001 -> scale -28, frac 0.
  - 0x7FFF -> scale 28, frac 0.
- Back-pressure: stream 5 words with sow on word 0 and eow on word 4; hold out.rtr = 0 for 4 cycles mid-stream.
  - in_rtr falls once the 2 stages are full.
  - out data stay stable while stalled.
  - All 5 words emerge in order with sow/eow intact.
- Random out.rtr toggling over 1000 random words, checked against a reference model: no drops, no duplicates.
- Assert rst_n low while both stages are valid:
  - out.rts = 0 immediately.
  - After release, the first output is the first word sent after reset.
